// File: rtl/pkt_send_arbiter.sv
// -----------------------------------------------------------------------------
// pkt_send_arbiter
//   Round-robin scheduler that forwards whole packets from NUM_PORTS buffered
//   sources onto one 134-bit packet output. Each source is a FWFT data FIFO and
//   a 1-bit meta FIFO holding one entry per complete packet. A port is granted
//   only when it has a complete packet buffered. The grant holds until that
//   packet's tail word has been forwarded, so packets never interleave.
//
// Ports
//   i_sys_clk     clock, all logic on posedge
//   i_rst         asynchronous active-high reset
//   i_pkt_avail   per-port "at least one whole packet buffered"
//   o_meta_rden   one-cycle pop of the granted port's meta FIFO
//   i_data_empty  per-port data FIFO empty
//   o_data_rden   combinational pop of the granted port's data FIFO head
//   i_data        per-port FWFT head word, port k at [k*134 +: 134]
//   o_data_valid  o_data carries a word this cycle
//   o_data        forwarded word, tag [133:132]: 01 head, 11 body, 10 tail
//   o_grant_port  port currently or most recently granted
//   o_busy        arbiter is in SEND or GAP
//
// Handshake: o_data_valid qualifies o_data for exactly one cycle and there is
// no back-pressure, so the consumer must take every valid word. On the source
// side a data word is consumed in every cycle where o_data_rden[k] is high,
// and a meta entry in every cycle where o_meta_rden[k] is high.
// -----------------------------------------------------------------------------
module pkt_send_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_W     = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic                      i_sys_clk,
  input  logic                      i_rst,
  input  logic [NUM_PORTS-1:0]      i_pkt_avail,
  output logic [NUM_PORTS-1:0]      o_meta_rden,
  input  logic [NUM_PORTS-1:0]      i_data_empty,
  output logic [NUM_PORTS-1:0]      o_data_rden,
  input  logic [NUM_PORTS*134-1:0]  i_data,
  output logic                      o_data_valid,
  output logic [133:0]              o_data,
  output logic [PORT_W-1:0]         o_grant_port,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [1:0] TAG_TAIL = 2'b10;
  // GAP counts down from GAP_CYCLES-1 to 0, giving GAP_CYCLES cycles in GAP.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_e                 state_q, state_d;
  logic [PORT_W-1:0]      ptr_q, ptr_d;
  logic [PORT_W-1:0]      grant_q, grant_d;
  logic [NUM_PORTS-1:0]   meta_rden_q, meta_rden_d;
  logic                   valid_q, valid_d;
  logic [133:0]           data_q, data_d;
  logic [3:0]             gap_q, gap_d;

  logic [133:0]           port_word [NUM_PORTS];
  logic [133:0]           head_word;
  logic                   head_pop;
  logic                   pick_found;
  logic [PORT_W-1:0]      pick_idx;
  logic [PORT_W-1:0]      cand;
  int                     cand_sum;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
    assign port_word[k] = i_data[k*134 +: 134];
  end

  assign head_word = port_word[grant_q];
  assign head_pop  = (state_q == ST_SEND) && !i_data_empty[grant_q];

  // Round-robin search starting just after the last granted port, with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    cand_sum   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_sum = int'(ptr_q) + i;
      if (cand_sum >= NUM_PORTS) cand_sum = cand_sum - NUM_PORTS;
      cand = PORT_W'(cand_sum);
      if (!pick_found && i_pkt_avail[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    o_data_rden = '0;
    if (head_pop) o_data_rden[grant_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    meta_rden_d = '0;
    valid_d     = 1'b0;
    data_d      = data_q;
    gap_d       = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d               = pick_idx;
          ptr_d                 = pick_idx;
          meta_rden_d[pick_idx] = 1'b1;
          state_d               = ST_SEND;
        end
      end
      ST_SEND: begin
        // An empty data FIFO mid-packet just stalls; only a tail ends SEND.
        if (head_pop) begin
          data_d  = head_word;
          valid_d = 1'b1;
          if (head_word[133:132] == TAG_TAIL) begin
            if (GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_LAST;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PORT_W'(NUM_PORTS - 1);
      grant_q     <= '0;
      meta_rden_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      meta_rden_q <= meta_rden_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      gap_q       <= gap_d;
    end
  end

  assign o_meta_rden  = meta_rden_q;
  assign o_data_valid = valid_q;
  assign o_data       = data_q;
  assign o_grant_port = grant_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule
